lfsr_sequencer: RTL
===================

LFSR_SEQUENCER -- requirements
Module: lfsr_sequencer

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, output buffer depth in words; power of two, at least 2.
REQ-002 Port: clk_i  input  1  clock; all state updates on its rising edge.
REQ-003 Port: nreset_i  input  1  reset; asynchronous and active-low.
REQ-004 Port: start_i  input  1  one-cycle request to run a sequence; sampled only in IDLE.
REQ-005 Port: seed_i  input  MAX_PIXEL_BITS  seed value, captured on an accepted start_i.
REQ-006 Port: stop_i  input  MAX_PIXEL_BITS  stop value, captured on an accepted start_i.
REQ-007 Port: cfg_sel_o  output  1  configuration target to the LFSR stage: 0 selects seed, 1 selects stop.
REQ-008 Port: cfg_rdy_o  output  1  one-cycle configuration write strobe to the LFSR stage.
REQ-009 Port: cfg_data_o  output  MAX_PIXEL_BITS  configuration word to the LFSR stage.
REQ-010 Port: cfg_done_i  input  1  configuration acknowledge from the LFSR stage; arrives one cycle after the strobe.
REQ-011 Port: lfsr_en_o  output  1  LFSR advance enable; a low level makes the LFSR stage reload its seed.
REQ-012 Port: lfsr_data_i  input  MAX_PIXEL_BITS  current LFSR word.
REQ-013 Port: lfsr_rdy_i  input  1  lfsr_data_i holds a newly shifted word.
REQ-014 Port: lfsr_done_i  input  1  the LFSR word equals the stop value.
REQ-015 Port: pix_o  output  MAX_PIXEL_BITS  output stream data; equals the FIFO head.
REQ-016 Port: pix_valid_o  output  1  output word valid.
REQ-017 Port: pix_ready_i  input  1  downstream accepts the word.
REQ-018 Port: busy_o  output  1  high whenever the state is not IDLE.
REQ-019 Port: done_o  output  1  one-cycle pulse when a sequence completes.
REQ-020 Port: overflow_o  output  1  sticky flag: a word was dropped; cleared by an accepted start_i.
REQ-021 Port: count_o  output  16  number of words pushed in the current or last sequence; saturates at 16'hFFFF.

Function
REQ-022 FSM states: IDLE, CFG_SEED, WAIT_SEED, CFG_STOP, WAIT_STOP, SETTLE, RUN, DRAIN, DONE.
REQ-023 IDLE: start_i captures seed_i and stop_i, clears count_o and overflow_o, and moves to CFG_SEED.
REQ-024 CFG_SEED: one cycle with cfg_rdy_o=1, cfg_sel_o=0 and cfg_data_o=seed; moves to WAIT_SEED.
REQ-025 WAIT_SEED: holds until cfg_done_i=1, then moves to CFG_STOP.
REQ-026 CFG_STOP: one cycle with cfg_rdy_o=1, cfg_sel_o=1 and cfg_data_o=stop; WAIT_STOP then holds until cfg_done_i=1.
REQ-027 SETTLE: exactly 2 cycles with lfsr_en_o=0 so the LFSR reloads the seed under the new stop value; then moves to RUN.
REQ-028 RUN: lfsr_en_o=1 continuously; there is no backpressure to the LFSR, because dropping enable restarts the sequence.
REQ-029 RUN push: every cycle with lfsr_rdy_i=1 pushes lfsr_data_i into the FIFO and increments count_o.
REQ-030 RUN exit: when lfsr_done_i=1, lfsr_en_o drops the next cycle and the state moves to DRAIN.
REQ-031 The word equal to the stop value is pushed; lfsr_done_i already high on entry to RUN (seed equals stop) pushes zero words.
REQ-032 FIFO full at the same time as a push: the word is dropped, overflow_o is set, and count_o does not increment.
REQ-033 FIFO push and pop in the same cycle while full: the push is accepted.
REQ-034 Pop handshake: a pop occurs when pix_valid_o and pix_ready_i are both 1; pix_valid_o = FIFO not empty.
REQ-035 pix_o is held stable while pix_valid_o=1 and pix_ready_i=0.
REQ-036 FIFO pointers are log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH.
REQ-037 DRAIN: waits for FIFO empty; DONE then pulses done_o for one cycle and returns to IDLE.
REQ-038 start_i outside IDLE is ignored; cfg_done_i outside the WAIT states is ignored.
REQ-039 cfg_rdy_o, cfg_sel_o, cfg_data_o and lfsr_en_o are registered outputs.

Reset
REQ-040 Assertion of nreset_i, including mid-sequence, forces the following without waiting for a clock.
REQ-041 State forced to IDLE.
REQ-042 FIFO emptied.
REQ-043 Control outputs: cfg_rdy_o, cfg_sel_o, lfsr_en_o, pix_valid_o, busy_o, done_o and overflow_o forced to 0.
REQ-044 Data outputs: cfg_data_o, pix_o and count_o forced to 0.

Structure
REQ-045 The state enum and FIFO_DEPTH default belong in the shared parameters package, next to MAX_PIXEL_BITS.
REQ-046 The FIFO is one sub-module, sync_fifo, holding the storage array, pointers, and full/empty flags.

Verification
REQ-047 Nominal: seed 1, stop = LFSR word 10, pix_ready_i=1 -> 10 words in LFSR order, count_o=10, single done_o pulse, overflow_o=0.
REQ-048 Seed equals stop (both 5) -> zero words, pix_valid_o never high, done_o pulses, count_o=0.
REQ-049 Stop = word 20, pix_ready_i=0 during RUN, FIFO_DEPTH=4 -> first 4 words kept, overflow_o=1, count_o=4; after ready, 4 words drained, then done_o.
REQ-050 pix_ready_i toggled every cycle -> no word lost or duplicated while not full; pix_o stable while stalled.
REQ-051 nreset_i asserted in RUN -> all outputs 0 immediately; a following start_i completes normally.
REQ-052 start_i pulsed during RUN -> ignored; captured seed and stop values unchanged.

Source files
------------

// File: rtl/lfsr_sequencer_pkg.sv
// Shared parameters, state encoding and word width for the LFSR sequencer and its FIFO.
package lfsr_sequencer_pkg;

  localparam int MAX_PIXEL_BITS = 16;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [3:0] {
    IDLE,
    CFG_SEED,
    WAIT_SEED,
    CFG_STOP,
    WAIT_STOP,
    SETTLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; 1-cycle write-to-read latency, head shown combinationally (0 when empty).
// A push while full is refused unless a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             nreset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             push_ok_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             pop_ok;

  // Extra pointer bit tells full from empty when the index bits match.
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok    = pop_i & ~empty_o;
  assign push_ok_o = push_i & (~full_o | pop_ok);
  assign data_o    = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok_o) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)    rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok_o) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/lfsr_sequencer.sv
// Configures an external LFSR with seed/stop, streams its words through a FIFO, then drains.
// The LFSR is never stalled: words arriving while the FIFO is full are dropped and flagged.
module lfsr_sequencer
  import lfsr_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                      clk_i,
  input  logic                      nreset_i,
  input  logic                      start_i,
  input  logic [MAX_PIXEL_BITS-1:0] seed_i,
  input  logic [MAX_PIXEL_BITS-1:0] stop_i,
  output logic                      cfg_sel_o,
  output logic                      cfg_rdy_o,
  output logic [MAX_PIXEL_BITS-1:0] cfg_data_o,
  input  logic                      cfg_done_i,
  output logic                      lfsr_en_o,
  input  logic [MAX_PIXEL_BITS-1:0] lfsr_data_i,
  input  logic                      lfsr_rdy_i,
  input  logic                      lfsr_done_i,
  output logic [MAX_PIXEL_BITS-1:0] pix_o,
  output logic                      pix_valid_o,
  input  logic                      pix_ready_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      overflow_o,
  output logic [15:0]               count_o
);

  state_e                      state_q, state_d;
  logic [MAX_PIXEL_BITS-1:0]   seed_q, seed_d;
  logic [MAX_PIXEL_BITS-1:0]   stop_q, stop_d;
  logic [MAX_PIXEL_BITS-1:0]   cfg_data_q, cfg_data_d;
  logic [15:0]                 count_q, count_d;
  logic                        ovf_q, ovf_d;
  logic                        settle_q, settle_d;
  logic                        cfg_rdy_q, cfg_rdy_d;
  logic                        cfg_sel_q, cfg_sel_d;
  logic                        lfsr_en_q, lfsr_en_d;
  logic                        push, push_ok, fifo_full, fifo_empty;

  sync_fifo #(
    .WIDTH (MAX_PIXEL_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .nreset_i  (nreset_i),
    .push_i    (push),
    .data_i    (lfsr_data_i),
    .pop_i     (pix_valid_o & pix_ready_i),
    .data_o    (pix_o),
    .push_ok_o (push_ok),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    seed_d   = seed_q;
    stop_d   = stop_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    settle_d = settle_q;
    push     = 1'b0;
    unique case (state_q)
      IDLE: if (start_i) begin
        seed_d  = seed_i;
        stop_d  = stop_i;
        count_d = '0;
        ovf_d   = 1'b0;
        state_d = CFG_SEED;
      end
      CFG_SEED:  state_d = WAIT_SEED;
      WAIT_SEED: if (cfg_done_i) state_d = CFG_STOP;
      CFG_STOP:  state_d = WAIT_STOP;
      WAIT_STOP: if (cfg_done_i) begin
        state_d  = SETTLE;
        settle_d = 1'b0;
      end
      SETTLE: begin
        settle_d = 1'b1;
        if (settle_q) state_d = RUN;
      end
      RUN: begin
        push = lfsr_rdy_i;
        if (lfsr_done_i) state_d = DRAIN;
      end
      DRAIN: if (fifo_empty) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (push_ok && (count_q != 16'hFFFF)) count_d = count_q + 16'd1;
    if (push && !push_ok) ovf_d = 1'b1;

    // Strobes and enable are decoded from the next state so they line up with it.
    cfg_rdy_d  = (state_d == CFG_SEED) || (state_d == CFG_STOP);
    cfg_sel_d  = (state_d == CFG_STOP);
    lfsr_en_d  = (state_d == RUN);
    cfg_data_d = cfg_data_q;
    if (state_d == CFG_SEED)      cfg_data_d = seed_d;
    else if (state_d == CFG_STOP) cfg_data_d = stop_d;
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q    <= IDLE;
      seed_q     <= '0;
      stop_q     <= '0;
      cfg_data_q <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      settle_q   <= 1'b0;
      cfg_rdy_q  <= 1'b0;
      cfg_sel_q  <= 1'b0;
      lfsr_en_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      seed_q     <= seed_d;
      stop_q     <= stop_d;
      cfg_data_q <= cfg_data_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      settle_q   <= settle_d;
      cfg_rdy_q  <= cfg_rdy_d;
      cfg_sel_q  <= cfg_sel_d;
      lfsr_en_q  <= lfsr_en_d;
    end
  end

  assign cfg_rdy_o   = cfg_rdy_q;
  assign cfg_sel_o   = cfg_sel_q;
  assign cfg_data_o  = cfg_data_q;
  assign lfsr_en_o   = lfsr_en_q;
  assign pix_valid_o = ~fifo_empty;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign overflow_o  = ovf_q;
  assign count_o     = count_q;

endmodule
